clock_monitor: RTL and testbench

Measures an externally generated square wave (CLK_IN) against the system clock CLK. Reports high time and full period in CLK cycles, checks the period against a window, and flags a stalled or missing input. It is the receiving end of the clock stimulus that our clock generators and benches drive. It is used for on-chip and bench checks of derived or external clocks.

---
 rtl/clock_monitor.sv | 141 ++++++++++++++
 tb/tb_clock_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Measures high time and period of an asynchronous square wave in system-clock
// cycles, checks the period against a window and flags a stalled input.
module clock_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    parameter int PER_MIN = 18,
    parameter int PER_MAX = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             in_range,
    output logic             stalled,
    output logic [7:0]       meas_count
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [31:0]      PER_MIN_C = 32'(PER_MIN);
    localparam logic [31:0]      PER_MAX_C = 32'(PER_MAX);

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] hcnt, lcnt, idle_cnt;

    logic             rise_det, fall_det, any_edge, timeout_hit;
    logic [CNT_W-1:0] hcnt_inc, lcnt_inc, sum_sat;
    logic [CNT_W:0]   sum;
    logic [31:0]      period_ext;
    logic             new_in_range;

    // Two flops resolve metastability; the third holds the previous sample for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the pre-edge value of the one before.
            s1 <= clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_det = s2 & ~s3;
    assign fall_det = ~s2 & s3;
    assign any_edge = rise_det | fall_det;

    assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_W'(1);
    assign lcnt_inc = (lcnt == CNT_MAX) ? lcnt : lcnt + CNT_W'(1);

    // Period sum carries one extra bit so overflow can be clamped instead of wrapping.
    assign sum          = {1'b0, hcnt} + {1'b0, lcnt};
    assign sum_sat      = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    assign period_ext   = 32'(sum_sat);
    assign new_in_range = (period_ext >= PER_MIN_C) && (period_ext <= PER_MAX_C);

    // A detected edge in the same cycle as the timeout always wins.
    assign timeout_hit = (idle_cnt == TIMEOUT_C) && !any_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a plain flop, so all of them take the async reset.
            state      <= IDLE;
            hcnt       <= '0;
            lcnt       <= '0;
            idle_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            stalled    <= 1'b0;
            meas_count <= '0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                // Disabling discards any measurement in flight but keeps the last results.
                state    <= IDLE;
                hcnt     <= '0;
                lcnt     <= '0;
                idle_cnt <= '0;
                stalled  <= 1'b0;
            end else if (state == IDLE) begin
                state <= SYNC;
            end else if (timeout_hit) begin
                stalled  <= 1'b1;
                state    <= SYNC;
                hcnt     <= '0;
                lcnt     <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= any_edge ? '0 : idle_cnt + CNT_W'(1);
                case (state)
                    SYNC: begin
                        if (rise_det) begin
                            state <= HIGH;
                            hcnt  <= CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (fall_det) begin
                            state <= LOW;
                            lcnt  <= CNT_W'(1);
                        end else begin
                            hcnt <= hcnt_inc;
                        end
                    end
                    LOW: begin
                        if (rise_det) begin
                            period     <= sum_sat;
                            high_time  <= hcnt;
                            in_range   <= new_in_range;
                            meas_valid <= 1'b1;
                            meas_count <= meas_count + 8'd1;
                            stalled    <= 1'b0;
                            state      <= HIGH;
                            hcnt       <= CNT_W'(1);
                            lcnt       <= '0;
                        end else begin
                            lcnt <= lcnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: a default-width instance plus a narrow
// instance that exercises counter and sum saturation.
module tb_clock_monitor;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 1024;
    localparam int SAT_W       = 4;
    localparam int SAT_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clk_in;

    logic [CNT_W-1:0] period, high_time;
    logic             meas_valid, in_range, stalled;
    logic [7:0]       meas_count;

    logic [SAT_W-1:0] s_period, s_high_time;
    logic             s_meas_valid, s_in_range, s_stalled;
    logic [7:0]       s_meas_count;

    int total = 0;
    int bad   = 0;

    bit gen_on = 1'b0;
    int h_cyc  = 10;
    int l_cyc  = 10;

    clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .PER_MIN(18), .PER_MAX(22)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_in(clk_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .in_range(in_range), .stalled(stalled), .meas_count(meas_count)
    );

    clock_monitor #(.CNT_W(SAT_W), .TIMEOUT(SAT_TIMEOUT), .PER_MIN(18), .PER_MAX(22)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_in(clk_in),
        .period(s_period), .high_time(s_high_time), .meas_valid(s_meas_valid),
        .in_range(s_in_range), .stalled(s_stalled), .meas_count(s_meas_count)
    );

    always #5 clk = ~clk;

    // Square-wave source: h_cyc/l_cyc are read at the start of each phase, toggling on falling clk.
    initial begin
        clk_in = 1'b0;
        forever begin
            if (!gen_on) begin
                clk_in = 1'b0;
                @(negedge clk);
            end else begin
                clk_in = 1'b1;
                repeat (h_cyc) @(negedge clk);
                clk_in = 1'b0;
                repeat (l_cyc) @(negedge clk);
            end
        end
    end

    task automatic wait_valid(input bit sat, input int budget, input string tag, output int cyc);
        bit ok;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            ok = sat ? s_meas_valid : meas_valid;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no meas_valid within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        #1;
        total++; if (period !== '0)      begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
        total++; if (high_time !== '0)   begin bad++; $display("FAIL reset_high: got %0d want 0", high_time); end
        total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", meas_valid); end
        total++; if (in_range !== 1'b0)  begin bad++; $display("FAIL reset_in_range: got %b want 0", in_range); end
        total++; if (stalled !== 1'b0)   begin bad++; $display("FAIL reset_stalled: got %b want 0", stalled); end
        total++; if (meas_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", meas_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal;
        int cyc;
        h_cyc  = 10;
        l_cyc  = 10;
        gen_on = 1'b1;
        en     = 1'b1;
        wait_valid(0, 100, "nom_first", cyc);
        total++; if (period !== 16'd20)   begin bad++; $display("FAIL nom_period: got %0d want 20", period); end
        total++; if (high_time !== 16'd10) begin bad++; $display("FAIL nom_high: got %0d want 10", high_time); end
        total++; if (in_range !== 1'b1)   begin bad++; $display("FAIL nom_in_range: got %b want 1", in_range); end
        total++; if (meas_count !== 8'd1) begin bad++; $display("FAIL nom_count1: got %0d want 1", meas_count); end
        wait_valid(0, 40, "nom_second", cyc);
        total++; if (cyc != 20) begin bad++; $display("FAIL nom_spacing2: got %0d want 20 cycles", cyc); end
        wait_valid(0, 40, "nom_third", cyc);
        total++; if (cyc != 20) begin bad++; $display("FAIL nom_spacing3: got %0d want 20 cycles", cyc); end
        total++; if (meas_count !== 8'd3) begin bad++; $display("FAIL nom_count3: got %0d want 3", meas_count); end
        @(posedge clk);
        #1;
        total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL nom_pulse_width: got %b want 0", meas_valid); end
    endtask

    task automatic test_duty;
        int cyc;
        h_cyc = 4;
        l_cyc = 20;
        wait_valid(0, 60, "duty_mixed", cyc);
        wait_valid(0, 60, "duty_clean", cyc);
        total++; if (period !== 16'd24)   begin bad++; $display("FAIL duty_period: got %0d want 24", period); end
        total++; if (high_time !== 16'd4) begin bad++; $display("FAIL duty_high: got %0d want 4", high_time); end
        total++; if (in_range !== 1'b0)   begin bad++; $display("FAIL duty_in_range: got %b want 0", in_range); end
        h_cyc = 10;
        l_cyc = 10;
        wait_valid(0, 60, "duty_back_mixed", cyc);
        wait_valid(0, 60, "duty_back_clean", cyc);
        total++; if (period !== 16'd20)   begin bad++; $display("FAIL duty_back_period: got %0d want 20", period); end
        total++; if (in_range !== 1'b1)   begin bad++; $display("FAIL duty_back_in_range: got %b want 1", in_range); end
    endtask

    task automatic test_window;
        int cyc;
        int vh[4]   = '{9, 9, 11, 12};
        int vl[4]   = '{8, 9, 11, 11};
        int vp[4]   = '{17, 18, 22, 23};
        bit vin[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            h_cyc = vh[i];
            l_cyc = vl[i];
            wait_valid(0, 60, "win_mixed", cyc);
            wait_valid(0, 60, "win_clean", cyc);
            total++; if (period !== 16'(vp[i])) begin bad++; $display("FAIL win_period[%0d]: got %0d want %0d", i, period, vp[i]); end
            total++; if (in_range !== vin[i])   begin bad++; $display("FAIL win_in_range[%0d]: got %b want %b", i, in_range, vin[i]); end
        end
    endtask

    task automatic test_saturation;
        int cyc;
        h_cyc = 12;
        l_cyc = 10;
        wait_valid(1, 80, "sat_first", cyc);
        wait_valid(1, 80, "sat_second", cyc);
        total++; if (s_period !== 4'd15)    begin bad++; $display("FAIL sat_period: got %0d want 15", s_period); end
        total++; if (s_high_time !== 4'd12) begin bad++; $display("FAIL sat_high: got %0d want 12", s_high_time); end
        total++; if (s_in_range !== 1'b0)   begin bad++; $display("FAIL sat_in_range: got %b want 0", s_in_range); end
        total++; if (period !== 16'd22)     begin bad++; $display("FAIL sat_wide_period: got %0d want 22", period); end
    endtask

    task automatic test_stall;
        int cyc;
        logic [7:0] c;
        h_cyc = 10;
        l_cyc = 10;
        wait_valid(0, 60, "stall_pre1", cyc);
        wait_valid(0, 60, "stall_pre2", cyc);
        total++; if (period !== 16'd20) begin bad++; $display("FAIL stall_pre_period: got %0d want 20", period); end
        c      = meas_count;
        gen_on = 1'b0;
        @(negedge clk_in);
        repeat (TIMEOUT + 3) @(posedge clk);
        #1;
        total++; if (stalled !== 1'b0) begin bad++; $display("FAIL stall_early: got %b want 0", stalled); end
        @(posedge clk);
        #1;
        total++; if (stalled !== 1'b1)    begin bad++; $display("FAIL stall_set: got %b want 1", stalled); end
        total++; if (period !== 16'd20)   begin bad++; $display("FAIL stall_period_hold: got %0d want 20", period); end
        total++; if (high_time !== 16'd10) begin bad++; $display("FAIL stall_high_hold: got %0d want 10", high_time); end
        total++; if (in_range !== 1'b1)   begin bad++; $display("FAIL stall_in_range_hold: got %b want 1", in_range); end
        repeat (50) @(posedge clk);
        #1;
        total++; if (stalled !== 1'b1) begin bad++; $display("FAIL stall_held: got %b want 1", stalled); end
        gen_on = 1'b1;
        wait_valid(0, 80, "stall_restart", cyc);
        total++; if (stalled !== 1'b0)        begin bad++; $display("FAIL stall_clear: got %b want 0", stalled); end
        total++; if (meas_count !== c + 8'd1) begin bad++; $display("FAIL stall_count: got %0d want %0d", meas_count, c + 8'd1); end
        total++; if (period !== 16'd20)       begin bad++; $display("FAIL stall_restart_period: got %0d want 20", period); end
    endtask

    task automatic test_en_drop;
        int cyc;
        logic [7:0] c;
        bit seen;
        wait_valid(0, 60, "en_pre", cyc);
        c = meas_count;
        repeat (3) @(posedge clk);
        #1;
        en   = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= meas_valid;
        end
        total++; if (seen !== 1'b0)       begin bad++; $display("FAIL en_no_valid: got %b want 0", seen); end
        total++; if (meas_count !== c)    begin bad++; $display("FAIL en_count_hold: got %0d want %0d", meas_count, c); end
        total++; if (period !== 16'd20)   begin bad++; $display("FAIL en_period_hold: got %0d want 20", period); end
        total++; if (high_time !== 16'd10) begin bad++; $display("FAIL en_high_hold: got %0d want 10", high_time); end
        en = 1'b1;
        wait_valid(0, 80, "en_resume", cyc);
        total++; if (meas_count !== c + 8'd1) begin bad++; $display("FAIL en_resume_count: got %0d want %0d", meas_count, c + 8'd1); end
        total++; if (period !== 16'd20)       begin bad++; $display("FAIL en_resume_period: got %0d want 20", period); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        wait_valid(0, 60, "rst_pre", cyc);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (period !== '0)       begin bad++; $display("FAIL rstmid_period: got %0d want 0", period); end
        total++; if (high_time !== '0)    begin bad++; $display("FAIL rstmid_high: got %0d want 0", high_time); end
        total++; if (meas_count !== 8'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", meas_count); end
        total++; if (in_range !== 1'b0)   begin bad++; $display("FAIL rstmid_in_range: got %b want 0", in_range); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(0, 80, "rst_first", cyc);
        total++; if (cyc < 21)            begin bad++; $display("FAIL rstmid_two_rises: got %0d cycles want >= 21", cyc); end
        total++; if (meas_count !== 8'd1) begin bad++; $display("FAIL rstmid_count1: got %0d want 1", meas_count); end
        total++; if (period !== 16'd20)   begin bad++; $display("FAIL rstmid_period1: got %0d want 20", period); end
    endtask

    task automatic test_wrap;
        int cyc;
        h_cyc = 4;
        l_cyc = 4;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 255; i++) wait_valid(0, 40, "wrap_step", cyc);
        total++; if (meas_count !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", meas_count); end
        total++; if (period !== 16'd8)      begin bad++; $display("FAIL wrap_period: got %0d want 8", period); end
        wait_valid(0, 40, "wrap_last", cyc);
        total++; if (meas_count !== 8'd0)   begin bad++; $display("FAIL wrap_zero: got %0d want 0", meas_count); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_duty;
        test_window;
        test_saturation;
        test_stall;
        test_en_drop;
        test_reset_mid;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
